// File: rtl/mux_based_and_gate_mux2.sv
// 1-bit 2:1 multiplexer, y = sel ? d1 : d0; purely combinational, zero latency.
// No handshake; output follows inputs immediately.
module mux2 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  always_comb begin
    y = d0;
    if (sel) begin
      y = d1;
    end
  end

endmodule

// File: rtl/mux_based_and_gate.sv
// Bitwise AND of a and b built from 2:1 muxes; o is zero-latency, o_q is one cycle later.
// No handshake or backpressure; o_q clears synchronously on rst.
module mux_based_and_gate #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] o_d;

  // b selects: pass a when set, otherwise the constant-0 data input.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux2 u_mux2 (
      .d0  (1'b0),
      .d1  (a[i]),
      .sel (b[i]),
      .y   (o[i])
    );
  end

  always_comb begin
    o_d = o;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q <= '0;
    end else begin
      o_q <= o_d;
    end
  end

endmodule

// File: tb/tb_mux_based_and_gate.sv
// Directed and random vector bench for mux_based_and_gate at WIDTH=1 and WIDTH=8.
module tb_mux_based_and_gate;

  logic       clk;
  logic       rst;
  logic       a1, b1, o1, o_q1;
  logic [7:0] a8, b8, o8, o_q8;
  logic [7:0] exp8;

  int vectors;
  int miscompares;

  mux_based_and_gate #(.WIDTH(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .a   (a1),
    .b   (b1),
    .o   (o1),
    .o_q (o_q1)
  );

  mux_based_and_gate #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .a   (a8),
    .b   (b8),
    .o   (o8),
    .o_q (o_q8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [3:0] o1_tab;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    a1  = 1'b0;
    b1  = 1'b0;
    a8  = 8'h00;
    b8  = 8'h00;

    // Reset state
    @(posedge clk); #1;
    check("reset_o_q8", o_q8, 8'h00);
    check("reset_o_q1", {7'b0, o_q1}, 8'h00);

    // WIDTH=1 exhaustive truth table, combinational only
    o1_tab = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      a1 = i[1];
      b1 = i[0];
      #1;
      check($sformatf("truth_a%0d_b%0d", i[1], i[0]), {7'b0, o1}, {7'b0, o1_tab[i]});
    end

    @(negedge clk);
    rst = 1'b0;

    // Main pattern: immediate o, then registered copy
    a8 = 8'hF0; b8 = 8'h3C; #1;
    check("f0_3c_o", o8, 8'h30);
    @(posedge clk); #1;
    check("f0_3c_o_q", o_q8, 8'h30);

    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; #1;
    check("ff_00_o", o8, 8'h00);
    a8 = 8'hFF; b8 = 8'hFF; #1;
    check("ff_ff_o", o8, 8'hFF);
    a8 = 8'hAA; b8 = 8'h55; #1;
    check("aa_55_o", o8, 8'h00);
    @(posedge clk); #1;
    check("aa_55_o_q", o_q8, 8'h00);

    // Mid-stream reset held for two edges, o keeps following inputs
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_edge1_o_q", o_q8, 8'h00);
    check("rst_edge1_o", o8, 8'hFF);
    @(posedge clk); #1;
    check("rst_edge2_o_q", o_q8, 8'h00);
    check("rst_edge2_o", o8, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_o_q", o_q8, 8'hFF);

    // Random latency check: o_q trails a&b by exactly one edge
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      exp8 = a8 & b8;
      #1;
      check("rand_o", o8, exp8);
      @(posedge clk); #1;
      check("rand_o_q", o_q8, exp8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
